// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the distributed-arithmetic
// convolution engine and its coefficient ROM.
package conv_pkg;

  localparam int DA_ADDR_WIDTH     = 9;
  localparam int DA_ROM_DATA_WIDTH = 8;
  localparam int COEFF_WIDTH       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : conv_pkg

// File: rtl/da_rom_9.sv
// Distributed-arithmetic ROM: for a 9-bit address, returns the signed sum of
// the coefficients whose address bit is set. Purely combinational.
module da_rom_9
  import conv_pkg::*;
#(
  parameter logic [35:0] COEFFICIENTS = 36'h000010000
) (
  input  logic        [DA_ADDR_WIDTH-1:0]     addr,
  output logic signed [DA_ROM_DATA_WIDTH-1:0] data
);

  // Nine 4-bit terms stay within [-72, 63], so 8 bits never overflow.
  always_comb begin
    data = '0;
    for (int i = 0; i < DA_ADDR_WIDTH; i++) begin
      if (addr[i]) begin
        data = data + DA_ROM_DATA_WIDTH'(signed'(COEFFICIENTS[COEFF_WIDTH*i +: COEFF_WIDTH]));
      end
    end
  end

endmodule : da_rom_9

// File: rtl/da_conv_engine_9.sv
// Bit-serial DA engine: slices nine pixels MSB-first into ROM addresses and
// shift-accumulates the ROM outputs into one 3x3 convolution result.
module da_conv_engine_9
  import conv_pkg::*;
#(
  parameter logic [35:0] COEFFICIENTS = 36'h000010000,
  parameter int          DATA_WIDTH   = 8,
  parameter bit          SIGNED_DATA  = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [9*DATA_WIDTH-1:0]        pixels,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [DATA_WIDTH+7:0]   result
);

  localparam int             AW      = DATA_WIDTH + 8;
  localparam int             CW      = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]  CNT_TOP = CW'(DATA_WIDTH - 1);

  state_e                          state_q, state_d;
  logic        [CW-1:0]            cnt_q, cnt_d;
  logic signed [AW-1:0]            acc_q, acc_d;
  logic signed [AW-1:0]            result_q, result_d;
  logic        [DATA_WIDTH-1:0]    pix_q [DA_ADDR_WIDTH];
  logic        [DATA_WIDTH-1:0]    pix_d [DA_ADDR_WIDTH];

  logic        [DA_ADDR_WIDTH-1:0]     rom_addr;
  logic signed [DA_ROM_DATA_WIDTH-1:0] rom_data;
  logic signed [AW-1:0]                rom_ext;
  logic signed [AW-1:0]                acc_shl;
  logic signed [AW-1:0]                acc_step;
  logic                                accept;

  da_rom_9 #(
    .COEFFICIENTS (COEFFICIENTS)
  ) u_rom (
    .addr (rom_addr),
    .data (rom_data)
  );

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign accept = in_valid && in_ready;

  // NOTE: a default assignment first in every always_comb prevents latches
  // on paths that do not assign the signal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)        state_d = SHIFT;
      SHIFT:   if (cnt_q == '0)   state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it reads 0 for the whole reset window.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = rst_n;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    for (int i = 0; i < DA_ADDR_WIDTH; i++) begin
      rom_addr[i] = pix_q[i][DATA_WIDTH-1];
    end
    rom_ext = AW'(rom_data);
    acc_shl = acc_q <<< 1;
    // For two's-complement pixels the MSB plane carries negative weight.
    if (SIGNED_DATA && (cnt_q == CNT_TOP)) acc_step = acc_shl - rom_ext;
    else                                   acc_step = acc_shl + rom_ext;
  end

  always_comb begin
    pix_d    = pix_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          for (int i = 0; i < DA_ADDR_WIDTH; i++) begin
            pix_d[i] = pixels[i*DATA_WIDTH +: DATA_WIDTH];
          end
          acc_d = '0;
          cnt_d = CNT_TOP;
        end
      end
      SHIFT: begin
        for (int i = 0; i < DA_ADDR_WIDTH; i++) begin
          pix_d[i] = pix_q[i] << 1;
        end
        acc_d = acc_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) result_d = acc_step;
      end
      default: ;
    endcase
  end

  // NOTE: the pixel shift registers are a handful of flops, not a RAM, so
  // they take the async reset like everything else and never hold residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      for (int i = 0; i < DA_ADDR_WIDTH; i++) pix_q[i] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      for (int i = 0; i < DA_ADDR_WIDTH; i++) pix_q[i] <= pix_d[i];
    end
  end

  assign result = result_q;

endmodule : da_conv_engine_9

// File: tb/tb_da_conv_engine_9.sv
// Self-checking bench: seven engines with different coefficient/sign settings
// share one stimulus bus and are compared against a dot-product model.
module tb_da_conv_engine_9;

  localparam int NDUT = 7;
  localparam int DW   = 8;

  function automatic logic [35:0] coef_of(input int k);
    case (k)
      0:       return 36'h000010000;
      1:       return 36'hFFFFFFFFF;
      2:       return 36'h777777777;
      3:       return 36'h888888888;
      4:       return 36'h000000008;
      default: return 36'h3A5C1F7E9;
    endcase
  endfunction

  function automatic bit sgn_of(input int k);
    return (k == 4) || (k == 5);
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic out_ready;
  logic [9*DW-1:0] pixels;
  logic              in_ready_v  [NDUT];
  logic              out_valid_v [NDUT];
  logic signed [15:0] result_v   [NDUT];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    da_conv_engine_9 #(
      .COEFFICIENTS (coef_of(g)),
      .DATA_WIDTH   (DW),
      .SIGNED_DATA  (sgn_of(g))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[g]),
      .pixels    (pixels),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready),
      .result    (result_v[g])
    );
  end

  // Reference: plain signed dot product of coefficients and pixels.
  function automatic longint model(input int k, input logic [9*DW-1:0] px);
    logic [35:0] c;
    longint s, cv, pv;
    logic [3:0] cn;
    logic [DW-1:0] pn;
    c = coef_of(k);
    s = 0;
    for (int i = 0; i < 9; i++) begin
      cn = c[4*i +: 4];
      pn = px[DW*i +: DW];
      cv = longint'(signed'(cn));
      pv = sgn_of(k) ? longint'(signed'(pn)) : longint'(pn);
      s  = s + cv * pv;
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_results(input string tag, input logic [9*DW-1:0] px);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s_result%0d", tag, k), result_v[k], model(k, px));
    end
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!out_valid_v[0] && n < 40) begin
      step();
      n++;
    end
  endtask

  // Send one window, check latency and results, hold off the handshake for
  // 'hold' cycles while scrambling inputs, then complete the handshake.
  task automatic run_window(input string tag, input logic [9*DW-1:0] px, input int hold);
    int n;
    n = 0;
    while (!in_ready_v[0] && n < 20) begin
      step();
      n++;
    end
    check({tag, "_ready"}, in_ready_v[0], 1);
    in_valid  = 1'b1;
    pixels    = px;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    pixels   = 72'({$urandom, $urandom, $urandom});
    wait_out_valid(n);
    check({tag, "_latency"}, n, 8);
    check_results(tag, px);
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      pixels   = 72'({$urandom, $urandom, $urandom});
      step();
      check({tag, "_hold_valid"}, out_valid_v[0], 1);
      check({tag, "_hold_ready"}, in_ready_v[0], 0);
      check_results({tag, "_hold"}, px);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check({tag, "_drop_valid"}, out_valid_v[0], 0);
    check({tag, "_ready_after"}, in_ready_v[0], 1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [9*DW-1:0] px;
    int n, c1, c2;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pixels    = '0;
    step();
    step();
    check("rst_in_ready", in_ready_v[0], 0);
    check("rst_out_valid", out_valid_v[0], 0);
    check("rst_result", result_v[0], 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready_v[0], 1);
    step();

    // Centre pixel only, default centre-1 coefficients.
    px = 72'(200) << 32;
    run_window("centre", px, 0);
    check("centre_const", result_v[0], 200);

    // All pixels 255 against uniform coefficient sets.
    px = {9{8'hFF}};
    run_window("all255", px, 0);
    check("all255_m1", result_v[1], -2295);
    check("all255_p7", result_v[2], 16065);
    check("all255_m8", result_v[3], -18360);

    // Signed pixels: the sign plane must be subtracted.
    px = 72'(8'h80);
    run_window("neg128", px, 0);
    check("neg128_const", result_v[4], 1024);
    px = 72'(8'hFF);
    run_window("neg1", px, 0);
    check("neg1_const", result_v[4], 8);

    // Backpressure: five stalled cycles with noisy inputs.
    px = 72'({$urandom, $urandom, $urandom});
    run_window("bp", px, 5);

    // Back-to-back windows with out_ready tied high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    pixels    = {9{8'h01}};
    step();
    pixels = {9{8'h02}};
    wait_out_valid(n);
    c1 = cyc;
    check("b2b_first", result_v[0], 1);
    check_results("b2b_first", {9{8'h01}});
    step();
    wait_out_valid(n);
    c2 = cyc;
    in_valid = 1'b0;
    check("b2b_second", result_v[0], 2);
    check_results("b2b_second", {9{8'h02}});
    check("b2b_spacing", c2 - c1, 10);
    step();
    out_ready = 1'b0;

    // Random windows with random handshake delay.
    for (int t = 0; t < 16; t++) begin
      px = 72'({$urandom, $urandom, $urandom});
      run_window($sformatf("rnd%0d", t), px, $urandom_range(0, 3));
    end

    // Abort mid-SHIFT with an asynchronous reset.
    px = {9{8'h5A}};
    in_valid = 1'b1;
    pixels   = px;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid_v[0], 0);
    check("abort_in_ready", in_ready_v[0], 0);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("abort_result%0d", k), result_v[k], 0);
    end
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("abort_release_ready", in_ready_v[0], 1);
    px = 72'({$urandom, $urandom, $urandom});
    run_window("fresh", px, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_da_conv_engine_9
